// File: rtl/proc_pipe.sv
// Three-stage (decode / execute / write-back) datapath with a 2^AW-entry register file,
// valid/ready handshakes, back-pressure stall and write-back-to-execute forwarding.
// Optional feature: define PROC_PIPE_SAT_EN to make opcode 7 a saturating add (SATADD).
module proc_pipe #(
  parameter int DW = 8,
  parameter int AW = 3,
  localparam int IW = 4 + AW + 2 * DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] instr,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW:0]   res,
  output logic          res_valid,
  input  logic          out_ready
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [3:0] {
    OP_AND   = 4'd0,
    OP_ADD   = 4'd1,
    OP_FETCH = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SUB   = 4'd5,
    OP_ADDR  = 4'd6,
    OP_SAT   = 4'd7
  } op_e;

  logic [DW:0]   regs [DEPTH];

  // Decode-stage register
  logic          d_valid;
  logic [3:0]    d_op;
  logic [AW-1:0] d_dest;
  logic [DW-1:0] d_a;
  logic [DW-1:0] d_b;

  // Write-back stage: destination of the result currently held in res
  logic [AW-1:0] r_dest;

  logic          stall;
  logic          consume;
  logic [AW-1:0] ra;
  logic [AW-1:0] rb;
  logic [DW:0]   reg_a;
  logic [DW:0]   reg_b;
  logic [DW:0]   opa;
  logic [DW:0]   opb;
  logic [DW:0]   x_val;
  logic          x_has;
`ifdef PROC_PIPE_SAT_EN
  logic [DW:0]   sat_sum;
`endif

  assign stall    = res_valid && !out_ready;
  assign in_ready = !stall;
  assign consume  = res_valid && out_ready;

  assign ra  = d_a[AW-1:0];
  assign rb  = d_b[AW-1:0];
  assign opa = {1'b0, d_a};
  assign opb = {1'b0, d_b};

  // A result sitting in res has not been written yet, so register reads that hit
  // its destination must take it from res instead of the register file.
  always_comb begin
    reg_a = regs[ra];
    reg_b = regs[rb];
    if (res_valid && (r_dest == ra)) reg_a = res;
    if (res_valid && (r_dest == rb)) reg_b = res;
  end

  // NOTE: every output of this combinational block gets a default first, so no latch
  // is inferred for opcodes that produce no result.
  always_comb begin
    x_val = '0;
    x_has = 1'b0;
`ifdef PROC_PIPE_SAT_EN
    sat_sum = opa + opb;
`endif
    case (d_op)
      OP_AND:   begin x_val = opa & opb; x_has = 1'b1; end
      OP_ADD:   begin x_val = opa + opb; x_has = 1'b1; end
      OP_FETCH: begin x_val = reg_a;     x_has = 1'b1; end
      OP_OR:    begin x_val = opa | opb; x_has = 1'b1; end
      OP_XOR:   begin x_val = opa ^ opb; x_has = 1'b1; end
      OP_SUB:   begin x_val = opa - opb; x_has = 1'b1; end
      OP_ADDR: begin
        x_val = {1'b0, reg_a[DW-1:0]} + {1'b0, reg_b[DW-1:0]};
        x_has = 1'b1;
      end
`ifdef PROC_PIPE_SAT_EN
      OP_SAT: begin
        x_val = sat_sum[DW] ? '1 : sat_sum;
        x_has = 1'b1;
      end
`endif
      default: ;
    endcase
    x_has = x_has && d_valid;
  end

  // NOTE: sequential state is assigned with non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_valid   <= 1'b0;
      d_op      <= '0;
      d_dest    <= '0;
      d_a       <= '0;
      d_b       <= '0;
      res       <= '0;
      res_valid <= 1'b0;
      r_dest    <= '0;
    end else if (!stall) begin
      d_valid   <= in_valid;
      if (in_valid) begin
        {d_op, d_dest, d_b, d_a} <= instr;
      end
      res_valid <= x_has;
      if (x_has) begin
        res    <= x_val;
        r_dest <= d_dest;
      end
    end
  end

  // NOTE: the register file is reset because software relies on it reading zero after
  // reset; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (consume) begin
      regs[r_dest] <= res;
    end
  end

endmodule

// File: tb/tb_proc_pipe.sv
// Scoreboard bench for proc_pipe: stimulus pushes expected results, a monitor pops and
// compares each consumed result. Honours PROC_PIPE_SAT_EN for opcode 7 expectations.
module tb_proc_pipe;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int IW = 4 + AW + 2 * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] instr;
  logic          in_valid;
  logic          in_ready;
  logic [DW:0]   res;
  logic          res_valid;
  logic          out_ready;

  int errors = 0;
  int checks = 0;
  logic [DW:0] exp_q[$];

  proc_pipe #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .instr(instr), .in_valid(in_valid), .in_ready(in_ready),
    .res(res), .res_valid(res_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one instruction and hold it until accepted; push its expected result if any.
  task automatic send(input logic [3:0] op, input logic [2:0] dest, input logic [7:0] b,
                      input logic [7:0] a, input logic has, input logic [DW:0] exp);
    bit ok = 1'b0;
    instr    = {op, dest, b, a};
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    else if (has) exp_q.push_back(exp);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: a result is consumed on the next rising edge when res_valid && out_ready.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && res_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_res: got 0x%0h with no result expected at %0t", res, $time);
        end else begin
          check("res", 32'(res), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    instr     = '0;
    out_ready = 1'b1;
    #1;
    check("reset_res", 32'(res), 32'h0);
    check("reset_res_valid", 32'(res_valid), 32'h0);
    check("reset_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // 1: ADD with carry, result latency, FETCH keeps the full DW+1 value
    send(4'd1, 3'd2, 8'h01, 8'hFF, 1'b1, 9'h100);
    in_valid = 1'b0;
    check("latency_not_yet", 32'(res_valid), 32'h0);
    @(posedge clk);
    #1;
    check("latency_valid", 32'(res_valid), 32'h1);
    check("latency_res", 32'(res), 32'h100);
    idle(2);
    send(4'd2, 3'd6, 8'h00, 8'h02, 1'b1, 9'h100);

    // 2: AND then forwarded FETCH then ADDR reading the freshly written value
    send(4'd0, 3'd1, 8'h3C, 8'hF0, 1'b1, 9'h030);
    send(4'd2, 3'd4, 8'h00, 8'h01, 1'b1, 9'h030);
    send(4'd6, 3'd5, 8'h01, 8'h01, 1'b1, 9'h060);

    // 3: SUB with borrow, XOR, ADDR using only low DW bits of stored values
    send(4'd5, 3'd3, 8'h07, 8'h05, 1'b1, 9'h1FE);
    send(4'd4, 3'd7, 8'hFF, 8'hAA, 1'b1, 9'h055);
    send(4'd2, 3'd0, 8'h00, 8'h03, 1'b1, 9'h1FE);
    send(4'd6, 3'd4, 8'h07, 8'h03, 1'b1, 9'h153);
    send(4'd3, 3'd0, 8'h0F, 8'h50, 1'b1, 9'h05F);

    // 6: NOP writes nothing; opcode 7 depends on the build option
    send(4'd8, 3'd6, 8'h00, 8'h00, 1'b0, 9'h000);
    send(4'd2, 3'd0, 8'h00, 8'h06, 1'b1, 9'h100);
`ifdef PROC_PIPE_SAT_EN
    send(4'd7, 3'd6, 8'h20, 8'hF0, 1'b1, 9'h1FF);
    send(4'd2, 3'd0, 8'h00, 8'h06, 1'b1, 9'h1FF);
    send(4'd7, 3'd5, 8'h20, 8'h10, 1'b1, 9'h030);
`else
    send(4'd7, 3'd6, 8'h20, 8'hF0, 1'b0, 9'h000);
    send(4'd2, 3'd0, 8'h00, 8'h06, 1'b1, 9'h100);
`endif
    idle(3);

    // 4: back-pressure with three ADDs in flight
    out_ready = 1'b0;
    send(4'd1, 3'd1, 8'h01, 8'h01, 1'b1, 9'h002);
    fork
      begin
        send(4'd1, 3'd2, 8'h02, 8'h02, 1'b1, 9'h004);
        send(4'd1, 3'd3, 8'h03, 8'h03, 1'b1, 9'h006);
      end
      begin
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("stall_in_ready", 32'(in_ready), 32'h0);
          check("stall_res_hold", 32'(res), 32'h002);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    send(4'd2, 3'd0, 8'h00, 8'h01, 1'b1, 9'h002);
    send(4'd2, 3'd0, 8'h00, 8'h02, 1'b1, 9'h004);
    send(4'd2, 3'd0, 8'h00, 8'h03, 1'b1, 9'h006);
    idle(3);

    // 5: reset with two instructions in flight discards them and clears the file
    send(4'd1, 3'd2, 8'h05, 8'h05, 1'b1, 9'h00A);
    send(4'd1, 3'd5, 8'h02, 8'h01, 1'b1, 9'h003);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_res_valid", 32'(res_valid), 32'h0);
    check("midrst_res", 32'(res), 32'h0);
    check("midrst_in_ready", 32'(in_ready), 32'h1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    send(4'd2, 3'd0, 8'h00, 8'h02, 1'b1, 9'h000);
    send(4'd2, 3'd0, 8'h00, 8'h05, 1'b1, 9'h000);
    send(4'd2, 3'd0, 8'h00, 8'h03, 1'b1, 9'h000);

    in_valid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    idle(2);
    check("drain_pending", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/proc_pipe.md
Name: proc_pipe

Overview:
- Parametrised three-stage (decode / execute / write-back) datapath processor with a 2^AW-entry register file.
- Supersedes the fixed 8-bit AND/ADD/FETCH processor with configurable data width and a wider opcode set.
- Adds valid/ready handshakes on both ends, back-pressure stalling, and write-back-to-execute forwarding.
- Sits between the instruction sequencer and the result consumer.

Parameters:
DW, 8, operand data width; results are DW+1 bits (carry/borrow/flag in bit DW)
AW, 3, register-file index width; depth = 2^AW entries of DW+1 bits
IW, 4+AW+2*DW, instruction width (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
instr  input  IW  {opcode[3:0], dest[AW-1:0], srcB[DW-1:0], srcA[DW-1:0]}
in_valid  input  1  instr valid this cycle
in_ready  output  1  pipeline can accept instr
res  output  DW+1  result of instruction in write-back stage
res_valid  output  1  res holds a valid result
out_ready  input  1  consumer accepts res this cycle

Behaviour:
- Reset (async, immediate on rst):
  - res=0, res_valid=0, in_ready=1.
  - Decode/execute valid bits cleared.
  - All register-file entries = 0.
  - In-flight instructions are discarded with no write-back.
- Transfers:
  - Accept when in_valid && in_ready.
  - Result consumed when res_valid && out_ready.
- Stall:
  - stall = res_valid && !out_ready; in_ready = !stall.
  - While stalled, decode, execute and res registers all hold.
- Latency: an instruction accepted at edge N is decoded at N, presents res/res_valid after edge N+1, and is written to reg[dest] on the edge it is consumed. Throughput is 1 instruction/cycle with no stall.
- Opcodes (A=srcA, B=srcB, zero-extended to DW+1):
  - 0 AND: A&B
  - 1 ADD: A+B, carry in bit DW
  - 2 FETCH: reg[A[AW-1:0]]
  - 3 OR: A|B
  - 4 XOR: A^B
  - 5 SUB: A-B mod 2^(DW+1); bit DW = borrow
  - 6 ADDR: low DW bits of reg[A[AW-1:0]] + reg[B[AW-1:0]], carry in bit DW
  - 7: see Optional Feature
  - 8-15: NOP. Travels the pipeline, produces no res_valid, no write.
- Forwarding:
  - FETCH/ADDR source index equal to dest of the valid instruction in the res register uses res, not the regfile.
  - Applies while stalled too.
  - An instruction two or more ahead is already written; no forwarding needed.
- Write-back:
  - reg[dest] <= res exactly once per consumed result.
  - A stalled result is not written until consumed.
  - dest equal to a source of the same instruction reads the old value.
- Widths: no truncation of the DW+1 result; FETCH returns the stored DW+1 value intact.

Optional Feature:
- Macro: PROC_PIPE_SAT_EN
- Defined: opcode 7 = SATADD.
  - res[DW-1:0] = min(A+B, 2^DW-1).
  - res[DW] = 1 iff saturation occurred.
  - Writes back like ADD.
- Undefined: opcode 7 is a NOP; no saturation logic is synthesised.

Test Plan:
1. DW=8, AW=3: ADD A=0xFF B=0x01 dest=2, out_ready=1 -> res=0x100, res_valid=1 the cycle after the decode edge; later FETCH A=2 -> 0x100.
2. AND A=0xF0 B=0x3C dest=1, immediately followed by FETCH A=1 -> res 0x030 then 0x030 (forwarded); ADDR A=1 B=1 next -> 0x060.
3. SUB A=0x05 B=0x07 dest=3 -> res=0x1FE; XOR A=0xAA B=0xFF -> 0x055.
4. Three back-to-back ADDs (1+1, 2+2, 3+3) with out_ready=0 for 3 cycles -> in_ready=0, res holds 0x002, no loss; results 0x002, 0x004, 0x006 in order; each dest written once.
5. rst pulsed mid-stream with two in flight -> res_valid=0 and res=0 immediately; FETCH A=2 after release -> 0x000.
6. SATADD A=0xF0 B=0x20 -> 0x1FF with PROC_PIPE_SAT_EN; without the macro -> res_valid stays 0 and no write.
